// File: rtl/cpu_ctrl_fsm_mc_if.sv
// Control bundle between the multi-cycle controller and the 16-bit datapath.
// The controller sits on the master side; the datapath (or a bench) on the slave side.
interface cpu_ctrl_fsm_mc_if #(
  parameter int REG_ADDR_W = 4
);
  logic [15:0]           Instr;
  logic [4:0]            ALUFlags;
  logic                  RegEn;
  logic                  RAMEn;
  logic                  PCEn;
  logic                  Imm_s;
  logic                  Signed;
  logic                  RamAddrSelect;
  logic [1:0]            LoadInSelect;
  logic [1:0]            PCState;
  logic [3:0]            ALUOpCode;
  logic [REG_ADDR_W-1:0] RdestRegLoc;
  logic [REG_ADDR_W-1:0] RsrcRegLoc;
  logic [7:0]            Imm;
  logic                  CondOut;

  modport master (
    input  Instr, ALUFlags,
    output RegEn, RAMEn, PCEn, Imm_s, Signed, RamAddrSelect, LoadInSelect,
           PCState, ALUOpCode, RdestRegLoc, RsrcRegLoc, Imm, CondOut
  );

  modport slave (
    output Instr, ALUFlags,
    input  RegEn, RAMEn, PCEn, Imm_s, Signed, RamAddrSelect, LoadInSelect,
           PCState, ALUOpCode, RdestRegLoc, RsrcRegLoc, Imm, CondOut
  );
endinterface

// File: rtl/cpu_ctrl_fsm_mc.sv
// Multi-cycle control FSM for the 16-bit datapath: fetch/decode, ALU ops, load with
// configurable RAM latency, store, conditional branch/jump and set-on-condition.
module cpu_ctrl_fsm_mc #(
  parameter int REG_ADDR_W = 4,
  parameter int RD_LATENCY = 1,
  parameter int MUL_EN     = 1
) (
  input  logic              Clk,
  input  logic              Reset,
  cpu_ctrl_fsm_mc_if.master bus
);

  localparam int              CNT_W    = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RD_LATENCY - 1);

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_CMP  = 4'b0010;
  localparam logic [3:0] ALU_AND  = 4'b0011;
  localparam logic [3:0] ALU_OR   = 4'b0100;
  localparam logic [3:0] ALU_XOR  = 4'b0101;
  localparam logic [3:0] ALU_LSH  = 4'b0111;
  localparam logic [3:0] ALU_MUL  = 4'b1010;

  localparam logic [3:0] OP_RTYPE = 4'b0000;
  localparam logic [3:0] OP_SPEC  = 4'b0100;
  localparam logic [3:0] OP_ADDUI = 4'b0110;
  localparam logic [3:0] OP_SHIFT = 4'b1000;
  localparam logic [3:0] OP_BCOND = 4'b1100;

  localparam logic [3:0] EXT_LOAD = 4'b0000;
  localparam logic [3:0] EXT_STOR = 4'b0100;
  localparam logic [3:0] EXT_JCND = 4'b1100;
  localparam logic [3:0] EXT_SCND = 4'b1101;
  localparam logic [3:0] EXT_LSH  = 4'b0100;

  typedef enum logic [2:0] {
    FETCH   = 3'd0,
    EXEC    = 3'd1,
    LD_WAIT = 3'd2,
    LD_WB   = 3'd3,
    ST      = 3'd4,
    BR      = 3'd5
  } state_t;

  state_t           state_r;
  logic [15:0]      ir_r;
  logic [4:0]       flag_r;
  logic [CNT_W-1:0] lat_cnt_r;

  logic [3:0] op_s, ext_s, in_op_s, in_ext_s, cond_sel_s;
  logic       cond_s;

  logic       ex_valid_s, ex_imm_s, ex_flag_s, ex_scond_s, ex_cmp_s;
  logic [3:0] ex_alu_s;

  logic       reg_en_s, ram_en_s, pc_en_s, imm_sel_s, signed_s, ram_addr_sel_s;
  logic [1:0] load_in_sel_s, pc_state_s;
  logic [3:0] alu_op_s;

  assign op_s     = ir_r[15:12];
  assign ext_s    = ir_r[7:4];
  assign in_op_s  = bus.Instr[15:12];
  assign in_ext_s = bus.Instr[7:4];

  // Flag bits: N=4, Z=3, F=2, L=1, C=0.
  function automatic logic cond_eval(input logic [3:0] cond, input logic [4:0] flags);
    logic n, z, f, l, c, res;
    n = flags[4];
    z = flags[3];
    f = flags[2];
    l = flags[1];
    c = flags[0];
    case (cond)
      4'b0000: res = z;
      4'b0001: res = ~z;
      4'b0010: res = c;
      4'b0011: res = ~c;
      4'b0100: res = l;
      4'b0101: res = ~l;
      4'b0110: res = n;
      4'b0111: res = ~n;
      4'b1000: res = f;
      4'b1001: res = ~f;
      4'b1010: res = ~(l | z);
      4'b1011: res = l | z;
      4'b1100: res = ~(n | z);
      4'b1101: res = n | z;
      4'b1110: res = 1'b1;
      4'b1111: res = 1'b0;
      default: res = 1'b0;
    endcase
    return res;
  endfunction

  // Bcond keeps its condition next to the opcode; Jcond/Scond keep it in the low nibble.
  assign cond_sel_s = (op_s == OP_BCOND) ? ir_r[11:8] : ir_r[3:0];
  assign cond_s     = cond_eval(cond_sel_s, flag_r);

  // Decode of the EXEC-class instruction held in IR.
  always_comb begin
    ex_valid_s = 1'b0;
    ex_imm_s   = 1'b0;
    ex_flag_s  = 1'b0;
    ex_scond_s = 1'b0;
    ex_cmp_s   = 1'b0;
    ex_alu_s   = ALU_ADD;
    case (op_s)
      OP_RTYPE: begin
        case (ext_s)
          4'b0101, 4'b0110: begin ex_valid_s = 1'b1; ex_alu_s = ALU_ADD; ex_flag_s = 1'b1; end
          4'b1001, 4'b1010: begin ex_valid_s = 1'b1; ex_alu_s = ALU_SUB; ex_flag_s = 1'b1; end
          4'b1011: begin ex_valid_s = 1'b1; ex_alu_s = ALU_CMP; ex_flag_s = 1'b1; ex_cmp_s = 1'b1; end
          4'b0001: begin ex_valid_s = 1'b1; ex_alu_s = ALU_AND; end
          4'b0010: begin ex_valid_s = 1'b1; ex_alu_s = ALU_OR;  end
          4'b0011: begin ex_valid_s = 1'b1; ex_alu_s = ALU_XOR; end
          4'b1110: begin
            if (MUL_EN != 0) begin
              ex_valid_s = 1'b1;
              ex_alu_s   = ALU_MUL;
              ex_flag_s  = 1'b1;
            end else begin
              ex_valid_s = 1'b0;
            end
          end
          default: ex_valid_s = 1'b0;
        endcase
      end
      4'b0101, 4'b0110, 4'b0111: begin
        ex_valid_s = 1'b1; ex_imm_s = 1'b1; ex_alu_s = ALU_ADD; ex_flag_s = 1'b1;
      end
      4'b1001, 4'b1010: begin
        ex_valid_s = 1'b1; ex_imm_s = 1'b1; ex_alu_s = ALU_SUB; ex_flag_s = 1'b1;
      end
      4'b1011: begin
        ex_valid_s = 1'b1; ex_imm_s = 1'b1; ex_alu_s = ALU_CMP; ex_flag_s = 1'b1; ex_cmp_s = 1'b1;
      end
      4'b0001: begin ex_valid_s = 1'b1; ex_imm_s = 1'b1; ex_alu_s = ALU_AND; end
      4'b0010: begin ex_valid_s = 1'b1; ex_imm_s = 1'b1; ex_alu_s = ALU_OR;  end
      4'b0011: begin ex_valid_s = 1'b1; ex_imm_s = 1'b1; ex_alu_s = ALU_XOR; end
      4'b1110: begin
        if (MUL_EN != 0) begin
          ex_valid_s = 1'b1;
          ex_imm_s   = 1'b1;
          ex_alu_s   = ALU_MUL;
          ex_flag_s  = 1'b1;
        end else begin
          ex_valid_s = 1'b0;
        end
      end
      OP_SHIFT: begin
        if (ext_s == EXT_LSH) begin
          ex_valid_s = 1'b1;
          ex_alu_s   = ALU_LSH;
        end else if (ext_s[3:1] == 3'b000) begin
          ex_valid_s = 1'b1;
          ex_imm_s   = 1'b1;
          ex_alu_s   = ALU_LSH;
        end else begin
          ex_valid_s = 1'b0;
        end
      end
      OP_SPEC: begin
        if (ext_s == EXT_SCND) begin
          ex_valid_s = 1'b1;
          ex_scond_s = 1'b1;
        end else begin
          ex_valid_s = 1'b0;
        end
      end
      default: ex_valid_s = 1'b0;
    endcase
  end

  // Datapath controls from state and IR; Reset kills every write/update enable at once.
  always_comb begin
    reg_en_s       = 1'b0;
    ram_en_s       = 1'b0;
    pc_en_s        = 1'b0;
    imm_sel_s      = 1'b0;
    signed_s       = 1'b0;
    ram_addr_sel_s = 1'b0;
    load_in_sel_s  = 2'b00;
    pc_state_s     = 2'b00;
    alu_op_s       = ALU_ADD;
    case (state_r)
      FETCH: begin
        pc_en_s = 1'b0;
      end
      EXEC: begin
        pc_en_s = 1'b1;
        if (ex_valid_s) begin
          reg_en_s      = ~ex_cmp_s;
          imm_sel_s     = ex_imm_s;
          signed_s      = ex_imm_s & (op_s != OP_ADDUI);
          alu_op_s      = ex_alu_s;
          load_in_sel_s = ex_scond_s ? 2'b10 : 2'b00;
        end else begin
          reg_en_s = 1'b0;
        end
      end
      LD_WAIT: begin
        ram_addr_sel_s = 1'b1;
      end
      LD_WB: begin
        ram_addr_sel_s = 1'b1;
        load_in_sel_s  = 2'b01;
        reg_en_s       = 1'b1;
        pc_en_s        = 1'b1;
      end
      ST: begin
        ram_addr_sel_s = 1'b1;
        ram_en_s       = 1'b1;
        pc_en_s        = 1'b1;
      end
      BR: begin
        pc_en_s = 1'b1;
        if (cond_s) begin
          pc_state_s = (op_s == OP_BCOND) ? 2'b01 : 2'b10;
        end else begin
          pc_state_s = 2'b00;
        end
      end
      default: pc_en_s = 1'b0;
    endcase
    if (Reset) begin
      reg_en_s = 1'b0;
      ram_en_s = 1'b0;
      pc_en_s  = 1'b0;
    end else begin
      pc_state_s = pc_state_s;
    end
  end

  assign bus.RegEn         = reg_en_s;
  assign bus.RAMEn         = ram_en_s;
  assign bus.PCEn          = pc_en_s;
  assign bus.Imm_s         = imm_sel_s;
  assign bus.Signed        = signed_s;
  assign bus.RamAddrSelect = ram_addr_sel_s;
  assign bus.LoadInSelect  = load_in_sel_s;
  assign bus.PCState       = pc_state_s;
  assign bus.ALUOpCode     = alu_op_s;
  assign bus.RdestRegLoc   = ir_r[8 +: REG_ADDR_W];
  assign bus.RsrcRegLoc    = ir_r[0 +: REG_ADDR_W];
  assign bus.Imm           = ir_r[7:0];
  assign bus.CondOut       = cond_s;

  // State, instruction register, flag register and load-latency counter.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_r   <= FETCH;
      ir_r      <= 16'h0000;
      flag_r    <= 5'b00000;
      lat_cnt_r <= '0;
    end else begin
      case (state_r)
        FETCH: begin
          ir_r      <= bus.Instr;
          lat_cnt_r <= '0;
          if (in_op_s == OP_SPEC && in_ext_s == EXT_LOAD) begin
            state_r <= LD_WAIT;
          end else if (in_op_s == OP_SPEC && in_ext_s == EXT_STOR) begin
            state_r <= ST;
          end else if (in_op_s == OP_BCOND || (in_op_s == OP_SPEC && in_ext_s == EXT_JCND)) begin
            state_r <= BR;
          end else begin
            state_r <= EXEC;
          end
        end
        EXEC: begin
          if (ex_valid_s && ex_flag_s) begin
            flag_r <= bus.ALUFlags;
          end
          state_r <= FETCH;
        end
        LD_WAIT: begin
          if (lat_cnt_r == CNT_LAST) begin
            lat_cnt_r <= '0;
            state_r   <= LD_WB;
          end else begin
            lat_cnt_r <= lat_cnt_r + CNT_W'(1);
          end
        end
        LD_WB:   state_r <= FETCH;
        ST:      state_r <= FETCH;
        BR:      state_r <= FETCH;
        default: state_r <= FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_ctrl_fsm_mc.sv
// Bench for cpu_ctrl_fsm_mc: two instances (load latency 3 with MUL, latency 1 without MUL)
// share the same stimulus and are each tracked by an instruction-level reference model.
module tb_cpu_ctrl_fsm_mc;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic [15:0] instr = 16'h0000;
  logic [4:0]  alu_flags = 5'b00000;

  always #5 Clk = ~Clk;

  cpu_ctrl_fsm_mc_if #(.REG_ADDR_W(4)) bus_a ();
  cpu_ctrl_fsm_mc_if #(.REG_ADDR_W(4)) bus_b ();

  assign bus_a.Instr    = instr;
  assign bus_a.ALUFlags = alu_flags;
  assign bus_b.Instr    = instr;
  assign bus_b.ALUFlags = alu_flags;

  cpu_ctrl_fsm_mc #(.REG_ADDR_W(4), .RD_LATENCY(3), .MUL_EN(1)) dut_a (
    .Clk(Clk), .Reset(Reset), .bus(bus_a));
  cpu_ctrl_fsm_mc #(.REG_ADDR_W(4), .RD_LATENCY(1), .MUL_EN(0)) dut_b (
    .Clk(Clk), .Reset(Reset), .bus(bus_b));

  logic [29:0] obs_a, obs_b;
  assign obs_a = {bus_a.RegEn, bus_a.RAMEn, bus_a.PCEn, bus_a.Imm_s, bus_a.Signed,
                  bus_a.RamAddrSelect, bus_a.LoadInSelect, bus_a.PCState, bus_a.ALUOpCode,
                  bus_a.RdestRegLoc, bus_a.RsrcRegLoc, bus_a.Imm};
  assign obs_b = {bus_b.RegEn, bus_b.RAMEn, bus_b.PCEn, bus_b.Imm_s, bus_b.Signed,
                  bus_b.RamAddrSelect, bus_b.LoadInSelect, bus_b.PCState, bus_b.ALUOpCode,
                  bus_b.RdestRegLoc, bus_b.RsrcRegLoc, bus_b.Imm};

  int err_cnt = 0;
  int chk_cnt = 0;
  int cyc_n   = 0;

  // Reference model: cycle index within the current instruction (0 = fetch).
  int          m_cyc   [2] = '{0, 0};
  logic [15:0] m_ir    [2] = '{16'h0000, 16'h0000};
  logic [4:0]  m_flags [2] = '{5'b00000, 5'b00000};
  int          m_lat   [2] = '{3, 1};
  bit          m_mul   [2] = '{1'b1, 1'b0};

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic bit is_load(input logic [15:0] w);
    return (w[15:12] == 4'h4) && (w[7:4] == 4'h0);
  endfunction
  function automatic bit is_store(input logic [15:0] w);
    return (w[15:12] == 4'h4) && (w[7:4] == 4'h4);
  endfunction
  function automatic bit is_branch(input logic [15:0] w);
    return (w[15:12] == 4'hC) || ((w[15:12] == 4'h4) && (w[7:4] == 4'hC));
  endfunction
  function automatic bit is_scond(input logic [15:0] w);
    return (w[15:12] == 4'h4) && (w[7:4] == 4'hD);
  endfunction
  function automatic int instr_len(input logic [15:0] w, input int lat);
    return is_load(w) ? (2 + lat) : 2;
  endfunction

  function automatic logic spec_cond(input logic [3:0] c, input logic [4:0] f);
    logic n, z, ff, l, cy;
    logic [15:0] truth;
    n = f[4]; z = f[3]; ff = f[2]; l = f[1]; cy = f[0];
    truth = {1'b0, 1'b1, n | z, ~(n | z), l | z, ~(l | z), ~ff, ff,
             ~n, n, ~l, l, ~cy, cy, ~z, z};
    return truth[c];
  endfunction

  // The R-type ext nibble and the immediate opcode nibble share one operation map.
  function automatic int alu_for(input logic [3:0] nib, input bit imm, input bit mul);
    case (nib)
      4'h5, 4'h6: return 0;
      4'h7:       return imm ? 0 : -1;
      4'h9, 4'hA: return 1;
      4'hB:       return 2;
      4'h1:       return 3;
      4'h2:       return 4;
      4'h3:       return 5;
      4'hE:       return mul ? 10 : -1;
      default:    return -1;
    endcase
  endfunction

  function automatic int exec_alu(input logic [15:0] w, input bit mul);
    if (w[15:12] == 4'h0) return alu_for(w[7:4], 1'b0, mul);
    if (w[15:12] == 4'h8) return ((w[7:4] == 4'h4) || (w[7:4] <= 4'h1)) ? 7 : -1;
    return alu_for(w[15:12], 1'b1, mul);
  endfunction

  task automatic model_check(input int k, input string name, input logic [29:0] obs, input logic obs_c);
    logic [15:0] w;
    int          c, a;
    logic        re, me, pe, is, sg, ras, cv, crel;
    logic [1:0]  lis, pcs;
    logic [3:0]  alu;
    w = m_ir[k]; c = m_cyc[k];
    re = 1'b0; me = 1'b0; pe = 1'b0; is = 1'b0; sg = 1'b0; ras = 1'b0; cv = 1'b0; crel = 1'b0;
    lis = 2'b00; pcs = 2'b00; alu = 4'b0000;
    if (c != 0) begin
      if (is_load(w)) begin
        ras = 1'b1;
        if (c == m_lat[k] + 1) begin lis = 2'b01; re = 1'b1; pe = 1'b1; end
      end else if (is_store(w)) begin
        ras = 1'b1; me = 1'b1; pe = 1'b1;
      end else if (is_branch(w)) begin
        pe = 1'b1; crel = 1'b1;
        cv = spec_cond((w[15:12] == 4'hC) ? w[11:8] : w[3:0], m_flags[k]);
        if (cv) pcs = (w[15:12] == 4'hC) ? 2'b01 : 2'b10;
      end else if (is_scond(w)) begin
        pe = 1'b1; re = 1'b1; lis = 2'b10; crel = 1'b1;
        cv = spec_cond(w[3:0], m_flags[k]);
      end else begin
        pe = 1'b1;
        a = exec_alu(w, m_mul[k]);
        if (a >= 0) begin
          re  = (a != 2);
          alu = 4'(a);
          is  = (w[15:12] != 4'h0) && !((w[15:12] == 4'h8) && (w[7:4] == 4'h4));
          sg  = is && (w[15:12] != 4'h6);
        end
      end
    end
    if (Reset) begin re = 1'b0; me = 1'b0; pe = 1'b0; end
    check_eq($sformatf("%s.ctrl@%0d", name, cyc_n), 32'(obs),
             32'({re, me, pe, is, sg, ras, lis, pcs, alu, w[11:8], w[3:0], w[7:0]}));
    if (crel) check_eq($sformatf("%s.cond@%0d", name, cyc_n), 32'(obs_c), 32'(cv));
  endtask

  task automatic model_adv(input int k);
    logic [15:0] w;
    int a;
    if (Reset) begin
      m_cyc[k] = 0; m_ir[k] = 16'h0000; m_flags[k] = 5'b00000;
    end else if (m_cyc[k] == 0) begin
      m_ir[k] = instr; m_cyc[k] = 1;
    end else begin
      w = m_ir[k];
      if (!is_load(w) && !is_store(w) && !is_branch(w) && !is_scond(w)) begin
        a = exec_alu(w, m_mul[k]);
        if (a inside {0, 1, 2, 10}) m_flags[k] = alu_flags;
      end
      if (m_cyc[k] >= instr_len(w, m_lat[k]) - 1) m_cyc[k] = 0;
      else m_cyc[k] = m_cyc[k] + 1;
    end
  endtask

  task automatic step(input logic rst, input logic [15:0] ins, input logic [4:0] fl);
    @(negedge Clk);
    Reset = rst; instr = ins; alu_flags = fl;
    #1;
    model_check(0, "A", obs_a, bus_a.CondOut);
    model_check(1, "B", obs_b, bus_b.CondOut);
    model_adv(0);
    model_adv(1);
    cyc_n++;
  endtask

  function automatic logic [15:0] rand_instr();
    logic [15:0] w;
    logic [31:0] r_ext, s_ext, i_op;
    w = 16'($urandom());
    r_ext = 32'hEBA96531;
    s_ext = 32'h0000DC40;
    i_op  = 32'hEBA97653;
    case ($urandom_range(0, 5))
      0: begin w[15:12] = 4'h0; w[7:4] = r_ext[4*$urandom_range(0, 7) +: 4]; end
      1: begin w[15:12] = 4'h4; w[7:4] = s_ext[4*$urandom_range(0, 3) +: 4]; end
      2: w[15:12] = 4'hC;
      3: w[15:12] = i_op[4*$urandom_range(0, 7) +: 4];
      4: begin w[15:12] = 4'h8; w[7:4] = ($urandom_range(0, 1) == 0) ? 4'h4 : 4'(w[4]); end
      default: w = w;
    endcase
    return w;
  endfunction

  initial begin
    int ras_n, wb_at, pcen_n;
    step(1'b1, 16'h0000, 5'b00000);
    step(1'b1, 16'h0000, 5'b00000);

    // Store aborted by a 3-cycle reset
    step(1'b0, 16'h4400, 5'b00000);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 16'h0000, 5'b00000);
      check_eq("rst_ramen_a", 32'(bus_a.RAMEn), 32'd0);
      check_eq("rst_ramen_b", 32'(bus_b.RAMEn), 32'd0);
    end

    // ADDI R3,#0xFF
    step(1'b0, 16'h53FF, 5'b00000);
    check_eq("post_rst_fetch", 32'({bus_a.PCEn, bus_a.RamAddrSelect, bus_a.RegEn}), 32'd0);
    step(1'b0, 16'h0000, 5'b00000);
    check_eq("addi", 32'({bus_a.RegEn, bus_a.Imm_s, bus_a.Signed, bus_a.PCEn, bus_a.ALUOpCode,
                          bus_a.RdestRegLoc, bus_a.Imm}),
             32'({1'b1, 1'b1, 1'b1, 1'b1, 4'b0000, 4'd3, 8'hFF}));

    // CMP R1,R1 with Z set, then BEQ taken
    step(1'b0, 16'h01B1, 5'b00000);
    step(1'b0, 16'h0000, 5'b01000);
    check_eq("cmp_regen", 32'(bus_a.RegEn), 32'd0);
    step(1'b0, 16'hC004, 5'b00000);
    step(1'b0, 16'h0000, 5'b00000);
    check_eq("beq_taken", 32'({bus_a.PCState, bus_a.CondOut}), 32'({2'b01, 1'b1}));

    // Same pair with Z clear: not taken
    step(1'b0, 16'h01B1, 5'b00000);
    step(1'b0, 16'h0000, 5'b00000);
    step(1'b0, 16'hC004, 5'b00000);
    step(1'b0, 16'h0000, 5'b00000);
    check_eq("beq_not_taken", 32'(bus_b.PCState), 32'd0);

    // Jcond on R7 (flags all clear, condition true)
    step(1'b0, 16'h4EC7, 5'b00000);
    step(1'b0, 16'h0000, 5'b00000);
    check_eq("jcond", 32'({bus_a.PCState, bus_a.RsrcRegLoc}), 32'({2'b10, 4'd7}));

    // Scond NE into R4 with Z=1
    step(1'b0, 16'h01B1, 5'b00000);
    step(1'b0, 16'h0000, 5'b01000);
    step(1'b0, 16'h44D1, 5'b00000);
    step(1'b0, 16'h0000, 5'b00000);
    check_eq("scond", 32'({bus_a.LoadInSelect, bus_a.RegEn, bus_a.CondOut}), 32'({2'b10, 1'b1, 1'b0}));

    // MUL: real op on A, NOP on B (B keeps Z=1, A takes Z=0)
    step(1'b0, 16'h01E2, 5'b00000);
    step(1'b0, 16'h0000, 5'b10111);
    check_eq("mul_nop_b", 32'({bus_b.RegEn, bus_b.PCEn, bus_b.ALUOpCode}), 32'({1'b0, 1'b1, 4'b0000}));
    check_eq("mul_a", 32'({bus_a.RegEn, bus_a.ALUOpCode}), 32'({1'b1, 4'b1010}));
    step(1'b0, 16'hC004, 5'b00000);
    step(1'b0, 16'h0000, 5'b00000);
    check_eq("flags_after_mul_a", 32'(bus_a.PCState), 32'd0);
    check_eq("flags_after_mul_b", 32'(bus_b.PCState), 32'd1);

    // LOAD R2,(R5) on the latency-3 instance
    ras_n = 0; wb_at = -1; pcen_n = 0;
    for (int i = 0; i < 5; i++) begin
      step(1'b0, (i == 0) ? 16'h4205 : 16'h0000, 5'b00000);
      if (bus_a.RamAddrSelect) ras_n++;
      if (bus_a.RegEn && bus_a.LoadInSelect == 2'b01) wb_at = i;
      if (bus_a.PCEn) pcen_n++;
    end
    check_eq("ld_ras_cycles", 32'(ras_n), 32'd4);
    check_eq("ld_wb_cycle", 32'(wb_at), 32'd4);
    check_eq("ld_pcen_count", 32'(pcen_n), 32'd1);
    step(1'b1, 16'h0000, 5'b00000);

    // Randomized traffic with occasional resets
    for (int i = 0; i < 4000; i++) begin
      step(($urandom_range(0, 99) == 0), rand_instr(), 5'($urandom()));
    end

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
